door_plant_model: RTL and testbench

Behavioural-synthesizable plant model of the garage door: the counterpart of the door controller FSM. It consumes the controller's motor commands (`ml` = drive down, `mr` = drive up). It integrates them into a door position and returns the limit-switch signals `sense_up` and `sense_down`. It sits beside the controller in the top-level test harness and the FPGA demo, closing the control loop without real hardware.

---
 rtl/door_plant_model.sv | 114 +++++++++++
 tb/tb_door_plant_model.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/door_plant_model.sv
// Garage door plant model: turns motor commands into a door position
// and reports the end-stop limit switches back to the controller.
module door_plant_model #(
  parameter int STEP_DIV     = 2000,
  parameter int TRAVEL_STEPS = 100,
  parameter int POS_W        = 8
) (
  input  logic             clk2m,
  input  logic             rst_n,
  input  logic             ml,
  input  logic             mr,
  output logic             sense_up,
  output logic             sense_down,
  output logic [POS_W-1:0] position,
  output logic             moving_up,
  output logic             moving_down,
  output logic             motor_fault
);

  localparam int PRE_W = $clog2(STEP_DIV);

  localparam logic [PRE_W-1:0] PRE_MAX =
    PRE_W'(STEP_DIV - 1);
  localparam logic [POS_W-1:0] POS_TOP =
    POS_W'(TRAVEL_STEPS);

  typedef enum logic [1:0] {
    IDLE,
    RUN_UP,
    RUN_DOWN,
    FAULT
  } state_t;

  state_t            state_q;
  logic [POS_W-1:0]  pos_q;
  logic [PRE_W-1:0]  pre_q;

  logic              at_top;
  logic              at_bot;
  logic              step;
  logic [POS_W-1:0]  pos_inc;
  logic [POS_W-1:0]  pos_dec;

  assign at_top  = (pos_q == POS_TOP);
  assign at_bot  = (pos_q == '0);
  assign step    = (pre_q == PRE_MAX);
  assign pos_inc = pos_q + 1'b1;
  assign pos_dec = pos_q - 1'b1;

  // Motor FSM, step prescaler and position integrator.
  // pre_q defaults to 0 so any state change or idle/fault
  // discards partial progress; a reversal at an end stop
  // parks in IDLE so the position can never wrap.
  always_ff @(posedge clk2m or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pos_q   <= '0;
      pre_q   <= '0;
    end else begin
      pre_q <= '0;
      if (ml && mr) begin
        state_q <= FAULT;
      end else begin
        unique case (state_q)
          IDLE: begin
            if (mr && !at_top)
              state_q <= RUN_UP;
            else if (ml && !at_bot)
              state_q <= RUN_DOWN;
          end
          RUN_UP: begin
            if (!mr && !ml) begin
              state_q <= IDLE;
            end else if (ml) begin
              state_q <= at_bot ? IDLE : RUN_DOWN;
            end else if (step) begin
              pos_q <= pos_inc;
              if (pos_inc == POS_TOP)
                state_q <= IDLE;
            end else begin
              pre_q <= pre_q + 1'b1;
            end
          end
          RUN_DOWN: begin
            if (!mr && !ml) begin
              state_q <= IDLE;
            end else if (mr) begin
              state_q <= at_top ? IDLE : RUN_UP;
            end else if (step) begin
              pos_q <= pos_dec;
              if (pos_dec == '0)
                state_q <= IDLE;
            end else begin
              pre_q <= pre_q + 1'b1;
            end
          end
          FAULT: begin
            if (!ml && !mr)
              state_q <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign position    = pos_q;
  assign sense_up    = at_top;
  assign sense_down  = at_bot;
  assign moving_up   = (state_q == RUN_UP);
  assign moving_down = (state_q == RUN_DOWN);
  assign motor_fault = (state_q == FAULT);

endmodule

// File: tb/tb_door_plant_model.sv
// Bench for door_plant_model: directed scenarios plus random
// command sequences against a cycle-count reference model.
module tb_door_plant_model;

  localparam int DIV = 4;
  localparam int T   = 5;
  localparam int PW  = 8;

  logic          clk2m = 1'b0;
  logic          rst_n = 1'b0;
  logic          ml    = 1'b0;
  logic          mr    = 1'b0;
  logic          sense_up;
  logic          sense_down;
  logic [PW-1:0] position;
  logic          moving_up;
  logic          moving_down;
  logic          motor_fault;

  int errors = 0;
  int checks = 0;

  // reference: door position, direction (0 stop,
  // 1 up, -1 down, 2 fault) and cycles run so far
  int m_pos;
  int m_dir;
  int m_run;

  logic [12:0] dut_vec;
  assign dut_vec = {sense_up, sense_down, moving_up,
                    moving_down, motor_fault, position};

  door_plant_model #(
    .STEP_DIV    (DIV),
    .TRAVEL_STEPS(T),
    .POS_W       (PW)
  ) dut (
    .clk2m      (clk2m),
    .rst_n      (rst_n),
    .ml         (ml),
    .mr         (mr),
    .sense_up   (sense_up),
    .sense_down (sense_down),
    .position   (position),
    .moving_up  (moving_up),
    .moving_down(moving_down),
    .motor_fault(motor_fault)
  );

  always #5 clk2m = ~clk2m;

  function automatic logic [12:0] exp_vec();
    return {m_pos == T, m_pos == 0, m_dir == 1,
            m_dir == -1, m_dir == 2, 8'(m_pos)};
  endfunction

  task automatic model_reset();
    m_pos = 0;
    m_dir = 0;
    m_run = 0;
  endtask

  task automatic model_edge(input logic l, input logic r);
    int want;
    if (l && r) begin
      m_dir = 2;
      m_run = 0;
    end else if (m_dir == 2) begin
      if (!l && !r) m_dir = 0;
    end else begin
      want = r ? 1 : (l ? -1 : 0);
      if (want == 0) begin
        m_dir = 0;
        m_run = 0;
      end else if (want != m_dir) begin
        m_run = 0;
        if ((want == 1 && m_pos == T) ||
            (want == -1 && m_pos == 0))
          m_dir = 0;
        else
          m_dir = want;
      end else begin
        m_run++;
        if (m_run == DIV) begin
          m_run = 0;
          m_pos += m_dir;
          if (m_pos == 0 || m_pos == T) m_dir = 0;
        end
      end
    end
  endtask

  task automatic cyc(input logic l, input logic r);
    ml = l;
    mr = r;
    @(posedge clk2m);
    model_edge(l, r);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk2m);
    ml = 1'b0;
    mr = 1'b0;
    rst_n = 1'b0;
    model_reset();
    #2;
    rst_n = 1'b1;
    @(negedge clk2m);
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (dut_vec !== 13'b01000_00000000) begin
      errors++;
      $display("FAIL reset_outputs got=%b want=%b",
               dut_vec, 13'b01000_00000000);
    end
  endtask

  task automatic test_open();
    do_reset();
    cyc(1'b0, 1'b1);
    checks++;
    if (moving_up !== 1'b1) begin
      errors++;
      $display("FAIL open_moving_up got=%b want=1", moving_up);
    end
    repeat (4) cyc(1'b0, 1'b1);
    checks++;
    if (position !== 8'd1 || sense_down !== 1'b0) begin
      errors++;
      $display("FAIL open_first_step pos=%0d sd=%b want 1/0",
               position, sense_down);
    end
    repeat (16) cyc(1'b0, 1'b1);
    checks++;
    if (position !== 8'd5 || sense_up !== 1'b1 ||
        moving_up !== 1'b0) begin
      errors++;
      $display("FAIL open_top pos=%0d su=%b mu=%b want 5/1/0",
               position, sense_up, moving_up);
    end
    repeat (3) cyc(1'b0, 1'b1);
    checks++;
    if (dut_vec !== exp_vec() || position !== 8'd5) begin
      errors++;
      $display("FAIL open_hold got=%b want=%b",
               dut_vec, exp_vec());
    end
  endtask

  task automatic test_close();
    cyc(1'b1, 1'b0);
    checks++;
    if (moving_down !== 1'b1) begin
      errors++;
      $display("FAIL close_start md=%b want=1", moving_down);
    end
    for (int i = 1; i <= 20; i++) begin
      cyc(1'b1, 1'b0);
      checks++;
      if (position !== 8'(5 - i / 4)) begin
        errors++;
        $display("FAIL close_step%0d pos=%0d want=%0d",
                 i, position, 5 - i / 4);
      end
    end
    checks++;
    if (sense_down !== 1'b1 || moving_down !== 1'b0) begin
      errors++;
      $display("FAIL close_end sd=%b md=%b want 1/0",
               sense_down, moving_down);
    end
    cyc(1'b0, 1'b0);
  endtask

  task automatic test_reversal();
    do_reset();
    repeat (10) cyc(1'b0, 1'b1);
    checks++;
    if (position !== 8'd2) begin
      errors++;
      $display("FAIL rev_pre pos=%0d want=2", position);
    end
    cyc(1'b1, 1'b0);
    checks++;
    if (moving_down !== 1'b1 || moving_up !== 1'b0) begin
      errors++;
      $display("FAIL rev_dir md=%b mu=%b want 1/0",
               moving_down, moving_up);
    end
    repeat (3) cyc(1'b1, 1'b0);
    checks++;
    if (position !== 8'd2) begin
      errors++;
      $display("FAIL rev_no_carry pos=%0d want=2", position);
    end
    cyc(1'b1, 1'b0);
    checks++;
    if (position !== 8'd1) begin
      errors++;
      $display("FAIL rev_step pos=%0d want=1", position);
    end
  endtask

  task automatic test_fault();
    do_reset();
    repeat (13) cyc(1'b0, 1'b1);
    checks++;
    if (position !== 8'd3 || moving_up !== 1'b1) begin
      errors++;
      $display("FAIL fault_pre pos=%0d mu=%b want 3/1",
               position, moving_up);
    end
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 1'b1);
      checks++;
      if (motor_fault !== 1'b1 || position !== 8'd3) begin
        errors++;
        $display("FAIL fault_hold mf=%b pos=%0d want 1/3",
                 motor_fault, position);
      end
    end
    cyc(1'b0, 1'b0);
    checks++;
    if (motor_fault !== 1'b0 || moving_up !== 1'b0 ||
        moving_down !== 1'b0) begin
      errors++;
      $display("FAIL fault_clear mf=%b mu=%b md=%b want 0",
               motor_fault, moving_up, moving_down);
    end
  endtask

  task automatic test_release();
    do_reset();
    for (int i = 0; i < 7; i++) begin
      cyc(1'b0, i != 3);
      checks++;
      if (position !== 8'd0) begin
        errors++;
        $display("FAIL release_c%0d pos=%0d want=0",
                 i, position);
      end
    end
    cyc(1'b0, 1'b0);
  endtask

  task automatic test_async_reset();
    do_reset();
    repeat (13) cyc(1'b0, 1'b1);
    #2;
    rst_n = 1'b0;
    mr = 1'b0;
    model_reset();
    #1;
    checks++;
    if (dut_vec !== 13'b01000_00000000) begin
      errors++;
      $display("FAIL async_reset got=%b want=%b",
               dut_vec, 13'b01000_00000000);
    end
    #1;
    rst_n = 1'b1;
    @(negedge clk2m);
  endtask

  task automatic test_random();
    int sel;
    int len;
    logic l;
    logic r;
    do_reset();
    for (int n = 0; n < 120; n++) begin
      sel = $urandom_range(0, 9);
      len = $urandom_range(1, 14);
      l = (sel >= 6);
      r = (sel >= 2 && sel <= 5) || sel == 9;
      for (int k = 0; k < len; k++) begin
        cyc(l, r);
        checks++;
        if (dut_vec !== exp_vec()) begin
          errors++;
          $display("FAIL random_n%0d got=%b want=%b",
                   n, dut_vec, exp_vec());
        end
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_open();
    test_close();
    test_reversal();
    test_fault();
    test_release();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
